// File: rtl/spi_tx_sequencer.sv
// Byte sequencer that frames SPI transfers: drives cs_n, loads and clocks an external shift register.
// Optional WAIT-state underflow timeout is enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_tx_sequencer #(
  parameter int SHIFT_DIV    = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       abort,
  output logic       sr_load,
  output logic [7:0] sr_pi,
  output logic       sr_en_L,
  output logic       cs_n,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] byte_cnt
`ifdef SPI_SEQ_TIMEOUT_EN
  ,
  output logic       timeout_err
`endif
);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, WAIT, HOLD} state_t;

  if (SHIFT_DIV < 2 || SHIFT_DIV > 255 || GUARD_CYCLES < 1 || GUARD_CYCLES > 255 ||
      TIMEOUT < 1) begin : g_bad_param
    $error("spi_tx_sequencer: parameter out of range");
  end

  localparam logic [7:0] DIV_LAST   = 8'(SHIFT_DIV - 1);
  localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q;
  logic [2:0] bit_q;
  logic       last_q;
  logic       rdy_en_q;
  logic       done_q;
  logic       hs;
  logic       abort_eff;
  logic       div_end;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt_q;
  logic          to_hit;
  logic          to_flag_q;

  // The last permitted idle WAIT cycle behaves like an abort (ready withdrawn too).
  assign to_hit    = (state_q == WAIT) && (wait_cnt_q == TW'(TIMEOUT - 1));
  assign abort_eff = abort | to_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      to_flag_q  <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == WAIT && !hs) ? wait_cnt_q + 1'b1 : '0;
      if (to_hit)
        to_flag_q <= 1'b1;
      else if (state_q == IDLE)
        to_flag_q <= 1'b0;
    end
  end

  assign timeout_err = done_q & to_flag_q;
`else
  assign abort_eff = abort;
`endif

  assign div_end = (cnt_q == DIV_LAST);
  assign s_ready = rdy_en_q & ((state_q == IDLE) | ((state_q == WAIT) & ~abort_eff));
  assign hs      = s_valid & s_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (hs) state_d = SETUP;
      SETUP: if (abort_eff) state_d = HOLD;
             else if (cnt_q == GUARD_LAST) state_d = LOAD;
      LOAD:  state_d = abort_eff ? HOLD : SHIFT;
      SHIFT: if (abort_eff) state_d = HOLD;
             else if (div_end && bit_q == 3'd7) state_d = last_q ? HOLD : WAIT;
      WAIT:  if (abort_eff) state_d = HOLD;
             else if (hs) state_d = LOAD;
      HOLD:  if (cnt_q == GUARD_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      last_q   <= 1'b0;
      sr_pi    <= '0;
      byte_cnt <= '0;
      done_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      done_q   <= (state_q == HOLD) && (state_d == IDLE);
      // cnt_q times guard phases and each SHIFT_DIV window; restarts on every state change.
      if (state_d != state_q) begin
        cnt_q <= '0;
        bit_q <= '0;
      end else if (state_q == SHIFT) begin
        cnt_q <= div_end ? 8'd0 : cnt_q + 8'd1;
        if (div_end) bit_q <= bit_q + 3'd1;
      end else if (state_q == SETUP || state_q == HOLD) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (hs) begin
        sr_pi  <= s_data;
        last_q <= s_last;
      end
      if (state_q == IDLE && hs)
        byte_cnt <= '0;
      else if (state_q == LOAD)
        byte_cnt <= sat_inc8(byte_cnt);
    end
  end

  assign cs_n       = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign sr_load    = (state_q == LOAD);
  assign sr_en_L    = ~((state_q == LOAD) | ((state_q == SHIFT) & div_end));
  assign frame_done = done_q;

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Scoreboard bench for spi_tx_sequencer: loaded bytes and end-of-frame byte counts are
// queued at stimulus time and compared when sr_load / frame_done appear.
module tb_spi_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_last, abort;
  logic [7:0] s_data;
  logic       s_ready, sr_load, sr_en_L, cs_n, busy, frame_done;
  logic [7:0] sr_pi, byte_cnt;
`ifdef SPI_SEQ_TIMEOUT_EN
  logic       timeout_err;
`endif

  spi_tx_sequencer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .abort(abort), .sr_load(sr_load), .sr_pi(sr_pi),
    .sr_en_L(sr_en_L), .cs_n(cs_n), .busy(busy), .frame_done(frame_done),
    .byte_cnt(byte_cnt)
`ifdef SPI_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] exp_byte_q[$];
  logic [7:0] exp_cnt_q[$];
  int         load_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: consume expectations as the DUT produces loads and frame ends.
  always @(negedge clk) begin
    if (!rst) begin
      if (sr_load) begin
        load_cyc_q.push_back(cyc);
        if (exp_byte_q.size() == 0) chk("unexp_load", exp_byte_q.size(), 1);
        else chk("sr_pi", sr_pi, exp_byte_q.pop_front());
      end
      if (frame_done) begin
        if (exp_cnt_q.size() == 0) chk("unexp_done", exp_cnt_q.size(), 1);
        else chk("byte_cnt", byte_cnt, exp_cnt_q.pop_front());
      end
    end
  end

  // Offer a byte; returns #1 after the handshake edge (first cycle after the handshake).
  task automatic send(input logic [7:0] d, input logic l);
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    chk("hs_ready", s_ready, 1);
    exp_byte_q.push_back(d);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    chk("done_seen", frame_done, 1);
    @(posedge clk); #1;
  endtask

  logic tr_cs[0:45], tr_ld[0:45], tr_en[0:45], tr_fd[0:45], tr_bz[0:45];
  int   pulses, bad_cs, bad_rdy, bad_en;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; abort = 1'b0;
    #2;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_en_L", sr_en_L, 1);
    chk("rst_load", sr_load, 0);
    chk("rst_pi", sr_pi, 8'h00);
    chk("rst_cnt", byte_cnt, 0);
    chk("rst_ready", s_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("ready_before_edge", s_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_edge", s_ready, 1);

    // Single-byte frame timing, cycle 0 = handshake cycle.
    exp_cnt_q.push_back(8'd1);
    send(8'hA5, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      tr_cs[k] = cs_n; tr_ld[k] = sr_load; tr_en[k] = sr_en_L;
      tr_fd[k] = frame_done; tr_bz[k] = busy;
    end
    pulses = 0;
    for (int k = 1; k <= 40; k++) if (!tr_en[k]) pulses++;
    chk("t1_cs_c1", tr_cs[1], 0);
    chk("t1_load_c2", tr_ld[2], 0);
    chk("t1_load_c3", tr_ld[3], 1);
    chk("t1_en_c3", tr_en[3], 0);
    chk("t1_en_c6", tr_en[6], 1);
    chk("t1_en_c7", tr_en[7], 0);
    chk("t1_en_c35", tr_en[35], 0);
    chk("t1_pulses", pulses, 9);
    chk("t1_hold_c37", {tr_bz[37], tr_cs[37], tr_fd[37]}, 3'b100);
    chk("t1_done_c38", {tr_bz[38], tr_cs[38], tr_fd[38]}, 3'b011);
    chk("t1_done_c39", tr_fd[39], 0);
    @(posedge clk); #1;

    // Back-to-back bytes with s_valid held high.
    load_cyc_q.delete();
    exp_cnt_q.push_back(8'd3);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b1);
    wait_done(200);
    chk("t2_loads", load_cyc_q.size(), 3);
    if (load_cyc_q.size() == 3) begin
      chk("t2_gap1", load_cyc_q[1] - load_cyc_q[0], 34);
      chk("t2_gap2", load_cyc_q[2] - load_cyc_q[1], 34);
    end

    // Second byte withheld for 100 cycles.
    exp_cnt_q.push_back(8'd2);
    send(8'h3C, 1'b0);
    repeat (40) @(posedge clk);
    bad_cs = 0; bad_rdy = 0; bad_en = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cs_n) bad_cs++;
      if (!s_ready) bad_rdy++;
      if (!sr_en_L || sr_load) bad_en++;
    end
    chk("t3_cs_low", bad_cs, 0);
    chk("t3_ready", bad_rdy, 0);
    chk("t3_no_pulse", bad_en, 0);
    @(posedge clk); #1;
    send(8'hC3, 1'b1);
    wait_done(200);

    // Abort at the third shift pulse.
    exp_cnt_q.push_back(8'd1);
    send(8'h5A, 1'b0);
    pulses = 0;
    for (int n = 0; n < 100 && pulses < 4; n++) begin
      @(negedge clk);
      if (!sr_en_L) pulses++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t4_hold1", {busy, cs_n, sr_en_L, frame_done}, 4'b1010);
    @(negedge clk);
    chk("t4_hold2", {busy, cs_n, sr_en_L, frame_done}, 4'b1010);
    @(negedge clk);
    chk("t4_done", {busy, cs_n, frame_done}, 3'b011);
    @(posedge clk); #1;

    // Abort in IDLE is ignored.
    abort = 1'b1;
    @(posedge clk); #1;
    chk("idle_abort", {busy, s_ready}, 2'b01);
    abort = 1'b0;

    // Abort beats a handshake in WAIT.
    exp_cnt_q.push_back(8'd1);
    send(8'h11, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    s_valid = 1'b1; s_data = 8'hEE; abort = 1'b1;
    @(negedge clk);
    chk("wait_abort_ready", s_ready, 0);
    @(posedge clk); #1;
    s_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("wait_abort_hold", {busy, s_ready, sr_load}, 3'b100);
    wait_done(20);

    // Reset mid-SHIFT, then a normal frame.
    send(8'h77, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1; #1;
    chk("mid_rst_outs", {cs_n, busy, sr_en_L, sr_load, frame_done, s_ready}, 6'b101000);
    chk("mid_rst_cnt", byte_cnt, 0);
    chk("mid_rst_pi", sr_pi, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (frame_done) chk("rst_no_done", frame_done, 0);
    end
    @(posedge clk); #1;
    exp_cnt_q.push_back(8'd1);
    send(8'h99, 1'b1);
    wait_done(100);

    chk("sb_bytes_left", exp_byte_q.size(), 0);
    chk("sb_cnts_left", exp_cnt_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
